// File: rtl/ppu_reg_pkg.sv
// Shared definitions for the PPU register bank: register map, status layout,
// PPUDATA state machine encoding, address constants and palette aliasing.
package ppu_reg_pkg;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_MASK    = 3'd1,
        REG_STATUS  = 3'd2,
        REG_OAMADDR = 3'd3,
        REG_OAMDATA = 3'd4,
        REG_SCROLL  = 3'd5,
        REG_ADDR    = 3'd6,
        REG_DATA    = 3'd7
    } reg_sel_e;

    localparam int STATUS_VBLANK   = 7;
    localparam int STATUS_SPRITE0  = 6;
    localparam int STATUS_OVERFLOW = 5;

    localparam logic [14:0] PALETTE_BASE = 15'h3F00;
    localparam logic [14:0] INC_ACROSS   = 15'd1;
    localparam logic [14:0] INC_DOWN     = 15'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2
    } data_state_e;

    // Sprite backdrop slots 0x10/14/18/1C fold onto the background ones.
    function automatic logic [4:0] pal_alias(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// Palette storage: one CPU port (combinational read, clocked write, aliased)
// plus NUM_PORTS render lookups registered with one enabled cycle of latency.
module ppu_palette_ram
    import ppu_reg_pkg::*;
#(
    parameter int PAL_DEPTH = 32,
    parameter int PAL_W     = 6,
    parameter int NUM_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         clk_en,
    input  logic                         cpu_we,
    input  logic [$clog2(PAL_DEPTH)-1:0] cpu_addr,
    input  logic [PAL_W-1:0]             cpu_wdata,
    output logic [PAL_W-1:0]             cpu_rdata,
    input  logic [4:0]                   pal_idx    [NUM_PORTS],
    output logic [PAL_W-1:0]             pal_colour [NUM_PORTS]
);
    localparam int IDX_W = $clog2(PAL_DEPTH);

    logic [PAL_W-1:0] mem [PAL_DEPTH];
    logic [IDX_W-1:0] cpu_map;

    always_comb begin
        cpu_map      = cpu_addr;
        cpu_map[4:0] = pal_alias(cpu_addr[4:0]);
    end

    assign cpu_rdata = mem[cpu_map];

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            mem[cpu_map] <= cpu_wdata;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_render
        // Any index with low bits 00 is transparent and shows the backdrop.
        always_ff @(posedge clk) begin
            if (clk_en) begin
                pal_colour[p] <= mem[IDX_W'((pal_idx[p][1:0] == 2'b00) ? 5'd0 : pal_idx[p])];
            end
        end
    end

endmodule

// File: rtl/ppu_register_bank.sv
// NES-style PPU CPU-facing register bank: scroll/address registers, status
// flags, PPUDATA VRAM access FSM (one request outstanding) and palette.
module ppu_register_bank
    import ppu_reg_pkg::*;
#(
    parameter int ADDR_W        = 14,
    parameter int PAL_DEPTH     = 32,
    parameter int PAL_W         = 6,
    parameter int NUM_PAL_PORTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              cpu_cs,
    input  logic              cpu_rw,
    input  logic [2:0]        cpu_sel,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              vram_req,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    input  logic              set_vblank,
    input  logic              clr_vblank,
    input  logic              set_sprite0,
    input  logic              set_overflow,
    input  logic              inc_x,
    input  logic              inc_y,
    input  logic              copy_x,
    input  logic              copy_y,
    output logic [14:0]       v_addr,
    output logic [2:0]        fine_x,
    output logic [7:0]        ctrl,
    output logic [7:0]        mask,
    output logic              nmi,
    input  logic [4:0]        pal_idx    [NUM_PAL_PORTS],
    output logic [PAL_W-1:0]  pal_colour [NUM_PAL_PORTS],
    output logic              err_overrun
);
    localparam int          PI_W       = $clog2(PAL_DEPTH);
    localparam logic [14:0] MIRROR_OFS = 15'h1000;

    data_state_e      state;
    reg_sel_e         sel;
    logic [14:0]      t;
    logic             w, vblank, sprite0, overflow;
    logic [7:0]       openbus, rd_buf, status_word, pal_word;
    logic [PAL_W-1:0] pal_rdata;
    logic [14:0]      v_scroll;
    logic [4:0]       cy;
    logic             acc, data_acc, busy, accept, is_pal, pal_we, status_rd;

    assign sel       = reg_sel_e'(cpu_sel);
    assign acc       = cpu_cs && clk_en;
    assign data_acc  = acc && (sel == REG_DATA);
    assign busy      = (state != IDLE);
    assign accept    = data_acc && !busy;
    assign is_pal    = (v_addr >= PALETTE_BASE);
    assign pal_we    = accept && !cpu_rw && is_pal;
    assign status_rd = acc && cpu_rw && (sel == REG_STATUS);
    assign nmi       = vblank && ctrl[7];

    always_comb begin
        status_word                  = {3'b000, openbus[4:0]};
        status_word[STATUS_VBLANK]   = vblank;
        status_word[STATUS_SPRITE0]  = sprite0;
        status_word[STATUS_OVERFLOW] = overflow;
        pal_word                     = openbus;
        pal_word[PAL_W-1:0]          = pal_rdata;
    end

    // Renderer scroll commands, applied in order x-inc, y-inc, copies.
    always_comb begin
        v_scroll = v_addr;
        cy       = v_addr[9:5];
        if (inc_x) begin
            if (v_scroll[4:0] == 5'd31) begin
                v_scroll[4:0] = 5'd0;
                v_scroll[10]  = ~v_scroll[10];
            end else begin
                v_scroll[4:0] = v_scroll[4:0] + 5'd1;
            end
        end
        if (inc_y) begin
            if (v_scroll[14:12] != 3'd7) begin
                v_scroll[14:12] = v_scroll[14:12] + 3'd1;
            end else begin
                v_scroll[14:12] = 3'd0;
                cy = v_scroll[9:5];
                if (cy == 5'd29) begin
                    cy           = 5'd0;
                    v_scroll[11] = ~v_scroll[11];
                end else if (cy == 5'd31) begin
                    cy = 5'd0;
                end else begin
                    cy = cy + 5'd1;
                end
                v_scroll[9:5] = cy;
            end
        end
        if (copy_x) begin
            v_scroll[10]  = t[10];
            v_scroll[4:0] = t[4:0];
        end
        if (copy_y) begin
            v_scroll[14:11] = t[14:11];
            v_scroll[9:5]   = t[9:5];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_addr      <= '0;
            t           <= '0;
            fine_x      <= '0;
            w           <= 1'b0;
            ctrl        <= '0;
            mask        <= '0;
            vblank      <= 1'b0;
            sprite0     <= 1'b0;
            overflow    <= 1'b0;
            openbus     <= '0;
            cpu_rdata   <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= data_acc && busy;
            if (clk_en) begin
                // A status read racing set_vblank suppresses the flag entirely.
                if (status_rd)        vblank <= 1'b0;
                else if (set_vblank)  vblank <= 1'b1;
                else if (clr_vblank)  vblank <= 1'b0;
                if (set_sprite0)      sprite0 <= 1'b1;
                else if (clr_vblank)  sprite0 <= 1'b0;
                if (set_overflow)     overflow <= 1'b1;
                else if (clr_vblank)  overflow <= 1'b0;

                v_addr <= v_scroll;
                if (acc && !cpu_rw) begin
                    openbus <= cpu_wdata;
                    case (sel)
                        REG_CTRL: begin
                            ctrl     <= cpu_wdata;
                            t[11:10] <= cpu_wdata[1:0];
                        end
                        REG_MASK: mask <= cpu_wdata;
                        REG_SCROLL: begin
                            if (!w) begin
                                t[4:0] <= cpu_wdata[7:3];
                                fine_x <= cpu_wdata[2:0];
                            end else begin
                                t[14:12] <= cpu_wdata[2:0];
                                t[9:5]   <= cpu_wdata[7:3];
                            end
                            w <= ~w;
                        end
                        REG_ADDR: begin
                            if (!w) begin
                                t[14:8] <= {1'b0, cpu_wdata[5:0]};
                            end else begin
                                t[7:0] <= cpu_wdata;
                                v_addr <= {t[14:8], cpu_wdata};
                            end
                            w <= ~w;
                        end
                        default: ;
                    endcase
                end
                if (accept) begin
                    v_addr <= v_addr + (ctrl[2] ? INC_DOWN : INC_ACROSS);
                end
                if (acc && cpu_rw) begin
                    case (sel)
                        REG_STATUS: begin
                            cpu_rdata <= status_word;
                            w         <= 1'b0;
                        end
                        REG_DATA: cpu_rdata <= !accept ? openbus : (is_pal ? pal_word : rd_buf);
                        default:  cpu_rdata <= openbus;
                    endcase
                end
            end
        end
    end

    // PPUDATA FSM; palette reads still refill the buffer from the mirrored nametable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            rd_buf     <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (accept && cpu_rw) begin
                        state     <= RD_REQ;
                        vram_req  <= 1'b1;
                        vram_we   <= 1'b0;
                        vram_addr <= ADDR_W'(is_pal ? (v_addr - MIRROR_OFS) : v_addr);
                    end else if (accept && !is_pal) begin
                        state      <= WR_REQ;
                        vram_req   <= 1'b1;
                        vram_we    <= 1'b1;
                        vram_addr  <= ADDR_W'(v_addr);
                        vram_wdata <= cpu_wdata;
                    end
                end
                RD_REQ: begin
                    if (vram_ack) begin
                        rd_buf   <= vram_rdata;
                        vram_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        vram_we  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ppu_palette_ram #(
        .PAL_DEPTH (PAL_DEPTH),
        .PAL_W     (PAL_W),
        .NUM_PORTS (NUM_PAL_PORTS)
    ) u_palette (
        .clk        (clk),
        .clk_en     (clk_en),
        .cpu_we     (pal_we),
        .cpu_addr   (v_addr[PI_W-1:0]),
        .cpu_wdata  (cpu_wdata[PAL_W-1:0]),
        .cpu_rdata  (pal_rdata),
        .pal_idx    (pal_idx),
        .pal_colour (pal_colour)
    );

endmodule

// File: doc/ppu_register_bank.md
PPU_REGISTER_BANK -- requirements
Module: ppu_register_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: VRAM address width; minimum 14.
REQ-002 SHALL have parameter PAL_DEPTH, default 32: palette entries, a power of two and at least 32.
REQ-003 SHALL have parameter PAL_W, default 6: palette colour width.
REQ-004 SHALL have parameter NUM_PAL_PORTS, default 2: independent render palette-lookup channels.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  PPU-cycle enable; state advances only when high, except reset.
REQ-008 cpu_cs, cpu_rw, cpu_sel  in  1, 1, 3  one-cycle access strobe; rw=1 means read; register index 0-7.
REQ-009 cpu_wdata / cpu_rdata  in / out  8 / 8  CPU write data / registered read data.
REQ-010 vram_req, vram_we, vram_addr, vram_wdata  out  1, 1, ADDR_W, 8  VRAM request; held until acknowledged.
REQ-011 vram_ack, vram_rdata  in  1, 8  one-cycle acknowledge; rdata valid with ack.
REQ-012 set_vblank, clr_vblank, set_sprite0, set_overflow  in  1 each  renderer event pulses.
REQ-013 inc_x, inc_y, copy_x, copy_y  in  1 each  scroll-counter commands.
REQ-014 v_addr, fine_x  out  15, 3  current VRAM address register v and fine X scroll.
REQ-015 ctrl, mask  out  8, 8  PPUCTRL and PPUMASK contents.
REQ-016 nmi  out  1  level, equal to vblank AND ctrl[7].
REQ-017 pal_idx[NUM_PAL_PORTS]  in  5 each  render palette index per channel.
REQ-018 pal_colour[NUM_PAL_PORTS]  out  PAL_W each  looked-up colour per channel.
REQ-019 err_overrun  out  1  pulses when a PPUDATA access is dropped.

Function
REQ-020 All register effects SHALL occur only on a cycle with cpu_cs and clk_en both high.
REQ-021 Writes to sel 0, 1, 3, 5 and 6 SHALL follow standard NES semantics for t, x and the write toggle w; sel 6 second write SHALL copy t into v.
REQ-022 Every CPU write SHALL load the open-bus latch with cpu_wdata.
REQ-023 Status read (sel 2) SHALL return {vblank, sprite0, overflow, openbus[4:0]} one cycle later, then clear vblank and w.
REQ-024 When a status read coincides with set_vblank, vblank SHALL stay 0 and nmi SHALL NOT assert.
REQ-025 clr_vblank SHALL clear vblank, sprite0 and overflow.
REQ-026 set_* SHALL take priority over clr_vblank on the same cycle, except as REQ-024 states.
REQ-027 The PPUDATA FSM SHALL have states IDLE, RD_REQ and WR_REQ.
REQ-028 On a PPUDATA read with v below 0x3F00, the FSM SHALL return the read buffer, go to RD_REQ, and load the buffer with vram_rdata on ack.
REQ-029 On a PPUDATA read with v at or above 0x3F00, it SHALL return {openbus[7:6], palette} immediately, refill the buffer from v-0x1000 through RD_REQ, and keep bits [7:PAL_W] from the open-bus latch.
REQ-030 On a PPUDATA write with v below 0x3F00, the FSM SHALL go to WR_REQ; a write at or above 0x3F00 SHALL write the palette in the same cycle with no VRAM request.
REQ-031 v SHALL increment by 1, or by 32 when ctrl[2] is set, at the PPUDATA access, wrapping modulo 2^15.
REQ-032 A PPUDATA access while the FSM is not IDLE SHALL be ignored with no increment, and err_overrun SHALL pulse for one cycle.
REQ-033 The FSM SHALL return to IDLE in the cycle after vram_ack.
REQ-034 Palette addresses 0x10, 0x14, 0x18 and 0x1C SHALL alias 0x00, 0x04, 0x08 and 0x0C on both read and write.
REQ-035 pal_colour SHALL be registered with 1-cycle latency and return entry 0 when pal_idx[1:0]==0.
REQ-036 inc_x SHALL increment coarse X and, on wrap from 31, toggle v[10].
REQ-037 inc_y SHALL increment fine Y; on fine-Y overflow it SHALL increment coarse Y; coarse Y 29 SHALL wrap to 0 and toggle v[11]; coarse Y 31 SHALL wrap to 0 with no toggle.
REQ-038 copy_x SHALL copy v[10] and v[4:0] from t; copy_y SHALL copy v[14:11] and v[9:5] from t.
REQ-039 A CPU write to v SHALL take priority over scroll commands on the same cycle.

Reset
REQ-040 reset SHALL zero v, t, fine_x, w, ctrl, mask, the flags, the open-bus latch, the read buffer and cpu_rdata.
REQ-041 reset SHALL force the FSM to IDLE and drop vram_req on the next cycle, aborting any pending transaction.
REQ-042 Palette contents SHALL be unchanged by reset.

Structure
REQ-043 Package ppu_reg_pkg SHALL hold: the register index enum, STATUS bit positions, PALETTE_BASE=0x3F00, the FSM state typedef and the increment constants.
REQ-044 The palette SHALL be sub-module ppu_palette_ram: one CPU read/write port, NUM_PAL_PORTS registered read ports, with aliasing applied inside.

Verification
REQ-045 Write sel 6 with 0x23 then 0x45, then read sel 7 twice with vram_rdata 0xAA then 0xBB: expect stale buffer, then 0xAA; vram_addr 0x2345 then 0x2346.
REQ-046 Write sel 7 at 0x3F10 with 0x2C, then read pal_idx 0x00: expect pal_colour 0x2C after 1 cycle, no vram_req, and v 0x3F11.
REQ-047 Assert set_vblank in the same cycle as a sel 2 read, with ctrl[7]=1: expect rdata[7]=0 and nmi never asserted.
REQ-048 Set v coarse Y=29 and fine Y=7, then inc_y: expect coarse Y 0, fine Y 0, and v[11] toggled; from coarse Y=31, expect no toggle.
REQ-049 Issue a second sel 7 write while in WR_REQ: expect an err_overrun pulse and v incremented only once.
REQ-050 Assert reset during RD_REQ: expect vram_req low next cycle, all registers zero, and palette preserved.
